// File: rtl/rgb_pixel_stage_pkg.sv
// Shared types and constants for the registered RGB pixel output stage.
package rgb_pkg;

    localparam int DEF_CHAN_W   = 4;
    localparam int DEF_NUM_CHAN = 3;
    localparam int PIX_W        = DEF_NUM_CHAN * DEF_CHAN_W;

    typedef enum logic [1:0] {
        MODE_PASS    = 2'd0,
        MODE_SOLID   = 2'd1,
        MODE_BARS    = 2'd2,
        MODE_CHECKER = 2'd3
    } mode_t;

    // Channel masks per bar, bit 2 = red, bit 1 = green, bit 0 = blue.
    localparam logic [7:0][2:0] BAR_LUT = {
        3'b111, 3'b110, 3'b101, 3'b100,
        3'b011, 3'b010, 3'b001, 3'b000
    };

endpackage

// File: rtl/rgb_pixel_stage_if.sv
// Video bundle between the pixel fetch/timing path and the pixel output stage.
interface rgb_pixel_stage_if #(
    parameter int PIX_W = rgb_pkg::PIX_W
);
    logic [PIX_W-1:0] pix_in;
    logic [PIX_W-1:0] blank_color;
    logic [PIX_W-1:0] solid_color;
    logic             h_disp;
    logic             v_disp;
    logic             hsync_in;
    logic             vsync_in;
    logic [1:0]       mode_req;
    logic [3:0]       bar_w_log2;
    logic [PIX_W-1:0] out_rgb;
    logic             hsync_out;
    logic             vsync_out;
    logic             active_out;
    logic [1:0]       mode_cur;

    modport master (
        output pix_in, blank_color, solid_color, h_disp, v_disp,
               hsync_in, vsync_in, mode_req, bar_w_log2,
        input  out_rgb, hsync_out, vsync_out, active_out, mode_cur
    );

    modport slave (
        input  pix_in, blank_color, solid_color, h_disp, v_disp,
               hsync_in, vsync_in, mode_req, bar_w_log2,
        output out_rgb, hsync_out, vsync_out, active_out, mode_cur
    );
endinterface

// File: rtl/rgb_pixel_stage_delay.sv
// Fixed-length shift register for a small signal bundle; DEPTH=0 collapses to a wire.
module sig_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);
    generate
        if (DEPTH == 0) begin : g_wire
            assign q_o = d_i;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage_q [DEPTH];

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
                end else begin
                    stage_q[0] <= d_i;
                    for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
                end
            end

            assign q_o = stage_q[DEPTH-1];
        end
    endgenerate
endmodule

// File: rtl/rgb_pixel_stage.sv
// Registered RGB output stage: aligns timing to late pixel data, blanks outside the
// active region, and substitutes test patterns with mode changes only at frame end.
module rgb_pixel_stage
    import rgb_pkg::*;
#(
    parameter int CHAN_W     = DEF_CHAN_W,
    parameter int NUM_CHAN   = DEF_NUM_CHAN,
    parameter int PIPE_DEPTH = 2,
    parameter int CNT_W      = 11,
    parameter int CHK_SHIFT  = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    rgb_pixel_stage_if.slave   bus
);
    localparam int BUS_W = NUM_CHAN * CHAN_W;

    logic [3:0] dl_in;
    logic [3:0] dl_out;
    logic       h_d, v_d, hs_d, vs_d;

    assign dl_in = {bus.h_disp, bus.v_disp, bus.hsync_in, bus.vsync_in};

    sig_delay_line #(
        .WIDTH (4),
        .DEPTH (PIPE_DEPTH)
    ) u_delay (
        .clk     (clk),
        .reset_n (reset_n),
        .d_i     (dl_in),
        .q_o     (dl_out)
    );

    assign {h_d, v_d, hs_d, vs_d} = dl_out;

    logic             h_prev_q, v_prev_q;
    logic [CNT_W-1:0] x_q, x_d, y_q, y_d;
    mode_t            mode_q, mode_d;
    logic             active, h_fall, v_fall;

    assign active = h_d & v_d;
    assign h_fall = h_prev_q & ~h_d;
    assign v_fall = v_prev_q & ~v_d;

    // Clears win over increments so a line/frame always starts at coordinate 0.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        mode_d = mode_q;
        if (!h_d)
            x_d = '0;
        else if (active)
            x_d = x_q + CNT_W'(1);
        if (!v_d)
            y_d = '0;
        else if (h_fall)
            y_d = y_q + CNT_W'(1);
        if (v_fall)
            mode_d = mode_t'(bus.mode_req);
    end

    logic [CNT_W-1:0] x_shift;
    logic [2:0]       bar_mask;
    logic             chk_bit;
    logic [BUS_W-1:0] bar_rgb;
    logic [BUS_W-1:0] chk_rgb;
    logic [BUS_W-1:0] rgb_d;

    assign x_shift  = x_q >> bus.bar_w_log2;
    assign bar_mask = BAR_LUT[x_shift[2:0]];
    assign chk_bit  = x_q[CHK_SHIFT] ^ y_q[CHK_SHIFT];
    assign chk_rgb  = {BUS_W{chk_bit}};

    // Channel 0 is the most significant slice; masks repeat R,G,B for wider buses.
    generate
        for (genvar gi = 0; gi < NUM_CHAN; gi++) begin : g_bar_chan
            assign bar_rgb[(NUM_CHAN-1-gi)*CHAN_W +: CHAN_W] = {CHAN_W{bar_mask[2 - (gi % 3)]}};
        end
    endgenerate

    always_comb begin
        rgb_d = bus.blank_color;
        if (active) begin
            case (mode_q)
                MODE_PASS:    rgb_d = bus.pix_in;
                MODE_SOLID:   rgb_d = bus.solid_color;
                MODE_BARS:    rgb_d = bar_rgb;
                MODE_CHECKER: rgb_d = chk_rgb;
                default:      rgb_d = bus.blank_color;
            endcase
        end
    end

    logic [BUS_W-1:0] out_rgb_q;
    logic             hsync_q, vsync_q, active_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            h_prev_q  <= 1'b0;
            v_prev_q  <= 1'b0;
            x_q       <= '0;
            y_q       <= '0;
            mode_q    <= MODE_PASS;
            out_rgb_q <= '0;
            hsync_q   <= 1'b0;
            vsync_q   <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            h_prev_q  <= h_d;
            v_prev_q  <= v_d;
            x_q       <= x_d;
            y_q       <= y_d;
            mode_q    <= mode_d;
            out_rgb_q <= rgb_d;
            hsync_q   <= hs_d;
            vsync_q   <= vs_d;
            active_q  <= active;
        end
    end

    assign bus.out_rgb    = out_rgb_q;
    assign bus.hsync_out  = hsync_q;
    assign bus.vsync_out  = vsync_q;
    assign bus.active_out = active_q;
    assign bus.mode_cur   = mode_q;
endmodule

// File: tb/tb_rgb_pixel_stage.sv
// Random/directed bench for rgb_pixel_stage: two configurations checked against a frame-level model.
module tb_rgb_pixel_stage;
    import rgb_pkg::*;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    logic [11:0] pix, blank, solid;
    logic        h, v, hs, vs;
    logic [1:0]  mreq;
    logic [3:0]  bwl;

    rgb_pixel_stage_if #(.PIX_W(12)) bus_a ();
    rgb_pixel_stage_if #(.PIX_W(12)) bus_b ();

    assign bus_a.pix_in = pix;       assign bus_b.pix_in = pix;
    assign bus_a.blank_color = blank; assign bus_b.blank_color = blank;
    assign bus_a.solid_color = solid; assign bus_b.solid_color = solid;
    assign bus_a.h_disp = h;         assign bus_b.h_disp = h;
    assign bus_a.v_disp = v;         assign bus_b.v_disp = v;
    assign bus_a.hsync_in = hs;      assign bus_b.hsync_in = hs;
    assign bus_a.vsync_in = vs;      assign bus_b.vsync_in = vs;
    assign bus_a.mode_req = mreq;    assign bus_b.mode_req = mreq;
    assign bus_a.bar_w_log2 = bwl;   assign bus_b.bar_w_log2 = bwl;

    rgb_pixel_stage #(.CHAN_W(4), .NUM_CHAN(3), .PIPE_DEPTH(2), .CNT_W(11), .CHK_SHIFT(4))
        dut_a (.clk(clk), .reset_n(reset_n), .bus(bus_a.slave));
    rgb_pixel_stage #(.CHAN_W(4), .NUM_CHAN(3), .PIPE_DEPTH(0), .CNT_W(4), .CHK_SHIFT(2))
        dut_b (.clk(clk), .reset_n(reset_n), .bus(bus_b.slave));

    // Reference model: per-configuration depth, counter width and checker size.
    localparam int DEP [2] = '{2, 0};
    localparam int CW  [2] = '{11, 4};
    localparam int CK  [2] = '{4, 2};

    logic [3:0]  hist [8192];
    int          cyc = 0, base = 0;
    int          xm [2], ym [2], modem [2];
    bit          ph [2], pv [2];
    logic [11:0] e_rgb [2];
    bit          e_act [2], e_hs [2], e_vs [2];

    int total = 0, bad = 0;
    bit rnd_mode = 0, fixed_pix = 0;

    function automatic logic [11:0] pattern(int mode, int x, int y, int chk, int shift,
                                            logic [11:0] p, logic [11:0] s);
        int b;
        case (mode)
            0: return p;
            1: return s;
            2: begin
                b = (x >> shift) % 8;
                return {((b / 4) % 2) ? 4'hF : 4'h0, ((b / 2) % 2) ? 4'hF : 4'h0, (b % 2) ? 4'hF : 4'h0};
            end
            default: return (((x >> chk) + (y >> chk)) % 2) ? 12'hFFF : 12'h000;
        endcase
    endfunction

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            xm[m] = 0; ym[m] = 0; modem[m] = 0; ph[m] = 0; pv[m] = 0;
            e_rgb[m] = 12'h000; e_act[m] = 0; e_hs[m] = 0; e_vs[m] = 0;
        end
        base = cyc;
    endtask

    task automatic model_step();
        logic [3:0] d;
        bit hd, vd, act;
        if (!reset_n) begin
            model_reset();
            return;
        end
        cyc++;
        hist[cyc] = {h, v, hs, vs};
        for (int m = 0; m < 2; m++) begin
            d   = (cyc - DEP[m] > base) ? hist[cyc - DEP[m]] : 4'b0000;
            hd  = d[3]; vd = d[2];
            act = hd && vd;
            e_rgb[m] = act ? pattern(modem[m], xm[m], ym[m], CK[m], int'(bwl), pix, solid) : blank;
            e_act[m] = act; e_hs[m] = d[1]; e_vs[m] = d[0];
            xm[m] = !hd ? 0 : (act ? (xm[m] + 1) % (1 << CW[m]) : xm[m]);
            ym[m] = !vd ? 0 : ((ph[m] && !hd) ? (ym[m] + 1) % (1 << CW[m]) : ym[m]);
            if (pv[m] && !vd) modem[m] = int'(mreq);
            ph[m] = hd; pv[m] = vd;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk($sformatf("a_rgb@%0d", cyc),  32'(bus_a.out_rgb),    32'(e_rgb[0]));
        chk($sformatf("a_act@%0d", cyc),  32'(bus_a.active_out), 32'(e_act[0]));
        chk($sformatf("a_hs@%0d", cyc),   32'(bus_a.hsync_out),  32'(e_hs[0]));
        chk($sformatf("a_vs@%0d", cyc),   32'(bus_a.vsync_out),  32'(e_vs[0]));
        chk($sformatf("a_mode@%0d", cyc), 32'(bus_a.mode_cur),   32'(modem[0]));
        chk($sformatf("b_rgb@%0d", cyc),  32'(bus_b.out_rgb),    32'(e_rgb[1]));
        chk($sformatf("b_act@%0d", cyc),  32'(bus_b.active_out), 32'(e_act[1]));
        chk($sformatf("b_hs@%0d", cyc),   32'(bus_b.hsync_out),  32'(e_hs[1]));
        chk($sformatf("b_vs@%0d", cyc),   32'(bus_b.vsync_out),  32'(e_vs[1]));
        chk($sformatf("b_mode@%0d", cyc), 32'(bus_b.mode_cur),   32'(modem[1]));
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
        check_all();
    endtask

    task automatic run_line(int n_act, int n_blk, bit vis, bit vsync);
        for (int i = 0; i < n_act + n_blk; i++) begin
            h   = (i < n_act);
            v   = vis;
            hs  = (i >= n_act + 1) && (i < n_act + 3);
            vs  = vsync;
            pix = fixed_pix ? 12'hA5C : 12'($urandom);
            if (rnd_mode) mreq = 2'($urandom_range(0, 3));
            step();
        end
    endtask

    task automatic frame(int lines, int n_act, int vblank);
        for (int l = 0; l < lines; l++) run_line(n_act, 4, 1'b1, 1'b0);
        for (int l = 0; l < vblank; l++) run_line(n_act, 4, 1'b0, l == 0);
    endtask

    // Asynchronous assertion between edges; outputs must clear without a clock.
    task automatic do_reset(int n);
        reset_n = 1'b0;
        #1;
        chk("rst_a_rgb",  32'(bus_a.out_rgb),    32'h0);
        chk("rst_a_hs",   32'(bus_a.hsync_out),  32'h0);
        chk("rst_a_vs",   32'(bus_a.vsync_out),  32'h0);
        chk("rst_a_act",  32'(bus_a.active_out), 32'h0);
        chk("rst_a_mode", 32'(bus_a.mode_cur),   32'h0);
        chk("rst_b_rgb",  32'(bus_b.out_rgb),    32'h0);
        chk("rst_b_mode", 32'(bus_b.mode_cur),   32'h0);
        model_reset();
        repeat (n) step();
        reset_n = 1'b1;
    endtask

    initial begin
        pix = 12'hFFF; blank = 12'h111; solid = 12'h0F0;
        h = 1'b1; v = 1'b1; hs = 1'b0; vs = 1'b0;
        mreq = 2'd0; bwl = 4'd2;
        model_reset();
        #2;
        do_reset(3);

        // PASS alignment with a constant pixel, then random pixels
        h = 1'b0; v = 1'b0;
        run_line(8, 4, 1'b0, 1'b1);
        fixed_pix = 1;
        frame(3, 10, 2);
        fixed_pix = 0;
        frame(3, 16, 2);

        // mode request mid-frame, including a short pulse of BARS that must be ignored
        run_line(16, 4, 1'b1, 1'b0);
        mreq = 2'd2;
        run_line(16, 4, 1'b1, 1'b0);
        mreq = 2'd1;
        run_line(16, 4, 1'b1, 1'b0);
        run_line(16, 4, 1'b0, 1'b1);
        run_line(16, 4, 1'b0, 1'b0);

        // SOLID frame, then BARS with 4-pixel bars, then 1-pixel bars on 20-pixel lines
        mreq = 2'd2;
        frame(3, 16, 2);
        bwl = 4'd2;
        frame(3, 32, 2);
        bwl = 4'd0;
        mreq = 2'd3;
        frame(2, 20, 2);

        // CHECKER over enough lines to reach y=16
        frame(20, 40, 2);

        // random modes, bar widths and line lengths
        rnd_mode = 1;
        for (int f = 0; f < 6; f++) begin
            bwl = 4'($urandom_range(0, 3));
            solid = 12'($urandom);
            blank = 12'($urandom);
            frame(int'($urandom_range(2, 6)), int'($urandom_range(8, 40)), 2);
        end
        rnd_mode = 0;
        blank = 12'h111;

        // reset in the middle of an active line
        mreq = 2'd1;
        frame(2, 20, 2);
        run_line(12, 4, 1'b1, 1'b0);
        h = 1'b1; v = 1'b1; pix = 12'hFFF;
        step();
        do_reset(3);
        for (int i = 0; i < 6; i++) begin
            pix = 12'($urandom);
            step();
        end
        run_line(4, 4, 1'b1, 1'b0);
        run_line(12, 4, 1'b0, 1'b1);
        frame(3, 16, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rgb_pixel_stage.md
Name: rgb_pixel_stage

Overview:
Parametrised, registered successor to the combinational RGB select stage. It sits between the sprite/pixel fetch path and the VGA pins. It delays the display-enable and sync inputs so they line up with pixel data that arrives late from the sprite ROM. It forces a programmable blank colour outside the active region, and it can replace the pixel data with built-in test patterns. Mode changes take effect only at frame boundaries, so no frame is torn.

Parameters:
CHAN_W, 4, bits per colour channel
NUM_CHAN, 3, number of colour channels (R,G,B order, channel 0 = MSB slice)
PIPE_DEPTH, 2, cycles by which pix_in lags the h_disp/v_disp/sync inputs (0 allowed)
CNT_W, 11, width of internal x/y pixel counters
CHK_SHIFT, 4, checkerboard square size = 2^CHK_SHIFT pixels

Ports:
clk  in  1  pixel clock
reset_n  in  1  asynchronous active-low reset
pix_in  in  NUM_CHAN*CHAN_W  pixel colour, valid PIPE_DEPTH cycles after matching h_disp/v_disp
blank_color  in  NUM_CHAN*CHAN_W  colour driven outside the active region (replaces fixed GND)
solid_color  in  NUM_CHAN*CHAN_W  colour for SOLID mode
h_disp  in  1  horizontal active-region flag
v_disp  in  1  vertical active-region flag
hsync_in  in  1  horizontal sync from timing generator
vsync_in  in  1  vertical sync from timing generator
mode_req  in  2  requested mode: 0 PASS, 1 SOLID, 2 BARS, 3 CHECKER
bar_w_log2  in  4  colour-bar width = 2^bar_w_log2 pixels
out_rgb  out  NUM_CHAN*CHAN_W  registered pixel output
hsync_out  out  1  aligned, registered hsync
vsync_out  out  1  aligned, registered vsync
active_out  out  1  registered h_disp&v_disp, aligned with out_rgb
mode_cur  out  2  mode currently in effect

Behaviour:
- Reset (async, reset_n=0): out_rgb=0, hsync_out=0, vsync_out=0, active_out=0, mode_cur=0 (PASS). Delay line, x/y counters and edge-detect flops all cleared. Release is synchronous to clk.
- Delay line: h_disp, v_disp, hsync_in and vsync_in each pass through PIPE_DEPTH flops, giving h_d, v_d, hs_d, vs_d. When PIPE_DEPTH=0 there are no flops and the signals pass straight through.
- Output register: one stage. Latency is PIPE_DEPTH+1 from the sync/display inputs and 1 from pix_in.
- active = h_d & v_d.
- Output colour when active=0: blank_color, regardless of mode.
- Output colour when active=1, selected by mode_cur:
  - PASS: pix_in.
  - SOLID: solid_color.
  - BARS: bar = (x >> bar_w_log2) mod 8. Channel c = all-ones if bar[2 - (c mod 3)] is 1, else 0. The 8 bars run black, blue, green, cyan, red, magenta, yellow, white.
  - CHECKER: all-ones on every channel if x[CHK_SHIFT]^y[CHK_SHIFT] is 1, else 0.
- x counter: cleared while h_d=0. It is incremented after each cycle with active=1, so the first active pixel has x=0. It wraps modulo 2^CNT_W.
- y counter: cleared while v_d=0. It is incremented on each falling edge of h_d while v_d=1, so the first active line has y=0. It wraps modulo 2^CNT_W.
- Mode update: mode_cur loads mode_req on the cycle where v_d falls (1->0, end of active frame). At all other times mode_req is ignored. If mode_req changes several times within a frame, only the value sampled on that edge counts. mode_cur is registered.
- Simultaneous v_d fall and h_d fall: the y counter is cleared (the clear takes priority over the increment) and mode_cur loads.
- Reset mid-frame: outputs go to their reset values immediately. After release, output is blank until the delay line refills, and the counters restart from the next h_d/v_d rise. The first partial frame after reset uses PASS.
- All arithmetic is unsigned. Channel width stays CHAN_W, with no truncation of pix_in.

Decomposition:
- Package rgb_pkg holds:
  - the mode_t enum (PASS, SOLID, BARS, CHECKER);
  - the BAR_LUT constant (8 x 3-bit channel masks);
  - the localparam for the pixel bus width, NUM_CHAN*CHAN_W.
- Sub-module sig_delay_line(WIDTH, DEPTH) is reused for the 4-bit sync/display bundle. With DEPTH=0 it is a pure wire.

Test Plan:
- Reset with reset_n=0 for 3 cycles mid-line, pix_in=12'hFFF, h_disp=v_disp=1 -> out_rgb=0, syncs=0, mode_cur=0 during reset. First non-blank out_rgb appears PIPE_DEPTH+1 cycles after release.
- PASS alignment, PIPE_DEPTH=2: raise h_disp=v_disp=1 at cycle t, pix_in=12'hA5C from t+2 -> active_out=1 and out_rgb=12'hA5C at t+3; h_disp falls at t+10 -> out_rgb=blank_color=12'h111 at t+13.
- BARS, bar_w_log2=2, one 32-pixel active line -> pixels 0-3 = 12'h000, 4-7 = 12'h00F, 8-11 = 12'h0F0, …, 28-31 = 12'hFFF.
- CHECKER, CHK_SHIFT=4, y=0: x=0..15 -> 12'h000, x=16..31 -> 12'hFFF. On line y=16 the pattern is inverted.
- Mode change timing: set mode_req=1 (solid_color=12'h0F0) mid-frame -> current frame stays PASS. After the v_disp fall, mode_cur=1 and the whole next frame outputs 12'h0F0. A pulse of mode_req=2 between two frame edges is never applied.
- Counter wrap, CNT_W=4, BARS with bar_w_log2=0: 20-pixel line -> x wraps after 15, and pixel 16 shows bar 0 (12'h000).
